// File: rtl/mmio_rr_arbiter.sv
// Two-master round-robin arbiter in front of a single MMIO slave port.
// Adds a bus timeout that completes a hung access with ERR_DATA.
module mmio_rr_arbiter #(
  parameter int ADDR_W = 32,
  parameter int XLEN = 32,
  parameter int TIMEOUT = 255,
  parameter logic [XLEN-1:0] ERR_DATA = XLEN'(32'hDEAD_BEEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [XLEN-1:0]   m0_wdata,
  output logic [XLEN-1:0]   m0_rdata,
  output logic              m0_ready,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [XLEN-1:0]   m1_wdata,
  output logic [XLEN-1:0]   m1_rdata,
  output logic              m1_ready,
  output logic              s_req,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [XLEN-1:0]   s_wdata,
  input  logic [XLEN-1:0]   s_rdata,
  input  logic              s_ready,
  output logic [1:0]        grant,
  output logic              err,
  input  logic              err_clr
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TLAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic TEN = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t        state;
  logic          own;
  logic          last;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          tmo;
  logic          done;
  logic [XLEN-1:0] rdata;

  assign busy = (state == BUSY);
  // s_ready takes priority over a coinciding timeout
  assign tmo = busy && TEN && !s_ready && (cnt == TLAST);
  assign done = busy && (s_ready || tmo);
  assign rdata = s_ready ? s_rdata : ERR_DATA;

  assign s_req = busy;
  assign s_we = busy && (own ? m1_we : m0_we);
  assign s_addr = own ? m1_addr : m0_addr;
  assign s_wdata = own ? m1_wdata : m0_wdata;

  assign m0_ready = done && !own;
  assign m1_ready = done && own;
  assign m0_rdata = m0_ready ? rdata : '0;
  assign m1_rdata = m1_ready ? rdata : '0;

  assign grant = busy ? (own ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      own <= 1'b0;
      last <= 1'b1;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (err_clr) err <= 1'b0;
      if (tmo) err <= 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (m0_req || m1_req) begin
            state <= BUSY;
            own <= (m0_req && m1_req) ? !last : m1_req;
          end
        end
        BUSY: begin
          if (done) begin
            state <= RELEASE;
            last <= own;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_rr_arbiter.sv
// Self-checking bench for mmio_rr_arbiter: vector table, directed corner
// sequences and randomized traffic against a transaction-level model.
module tb_mmio_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m1_addr, s_addr;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready;
  logic        s_req, s_we, s_ready;
  logic [31:0] s_wdata, s_rdata;
  logic [1:0]  grant;
  logic        err, err_clr;

  int errors = 0;
  int checks = 0;

  mmio_rr_arbiter #(
    .ADDR_W(16), .XLEN(32), .TIMEOUT(16), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .grant(grant), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // slave: small register file with configurable or random latency
  logic [31:0] mem [16];
  bit  hang = 1'b0;
  bit  rnd_mode = 1'b0;
  int  lat_cfg = 0;
  int  lat_rnd;
  int  scnt;

  assign s_ready = s_req && !hang &&
                   (scnt >= (rnd_mode ? lat_rnd : lat_cfg));
  assign s_rdata = s_req ? mem[s_addr[3:0]] : 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      scnt <= 0;
      lat_rnd <= 0;
    end else if (s_req) begin
      scnt <= scnt + 1;
      if (s_ready) begin
        scnt <= 0;
        if (s_we) mem[s_addr[3:0]] <= s_wdata;
        lat_rnd <= int'($urandom_range(0, 3));
      end
    end else begin
      scnt <= 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // protocol invariants sampled every cycle
  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("protocol", {31'h0,
          (grant != 2'b11) && (s_req == (grant != 2'b00)) &&
          !(m0_ready && m1_ready) &&
          (!m0_ready || grant == 2'b01) &&
          (!m1_ready || grant == 2'b10) &&
          (m0_ready || m0_rdata == 32'h0) &&
          (m1_ready || m1_rdata == 32'h0)}, 32'h1);
    end
  end

  typedef struct {
    logic r0, r1, we0, we1;
    logic [15:0] a0, a1;
    logic [31:0] d0, d1;
    logic [1:0] g1, g2;
    logic [31:0] x0, x1;
  } vec_t;

  vec_t tbl[10];

  task automatic run_round(input int idx, input vec_t v);
    logic [1:0] gs[$];
    logic [1:0] pg;
    logic [31:0] r0v, r1v;
    bit d0, d1;
    int cyc;
    @(posedge clk); #1;
    m0_req = v.r0; m0_we = v.we0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_req = v.r1; m1_we = v.we1; m1_addr = v.a1; m1_wdata = v.d1;
    pg = 2'b00; d0 = !v.r0; d1 = !v.r1; cyc = 0;
    r0v = 32'h0; r1v = 32'h0;
    while (!(d0 && d1) && cyc < 40) begin
      @(negedge clk);
      if (grant != 2'b00 && pg == 2'b00) gs.push_back(grant);
      pg = grant;
      if (m0_ready) begin d0 = 1'b1; r0v = m0_rdata; end
      if (m1_ready) begin d1 = 1'b1; r1v = m1_rdata; end
      @(posedge clk); #1;
      if (d0) m0_req = 1'b0;
      if (d1) m1_req = 1'b0;
      cyc++;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    chk($sformatf("vec%0d_done", idx), {30'h0, d0, d1}, 32'h3);
    chk($sformatf("vec%0d_g1", idx),
        {30'h0, gs.size() > 0 ? gs[0] : 2'b00}, {30'h0, v.g1});
    chk($sformatf("vec%0d_g2", idx),
        {30'h0, gs.size() > 1 ? gs[1] : 2'b00}, {30'h0, v.g2});
    if (v.r0 && !v.we0) chk($sformatf("vec%0d_rd0", idx), r0v, v.x0);
    if (v.r1 && !v.we1) chk($sformatf("vec%0d_rd1", idx), r1v, v.x1);
  endtask

  task automatic drive(input int k, input logic r, input logic we,
                       input logic [15:0] a, input logic [31:0] d);
    if (k == 0) begin
      m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d;
    end else begin
      m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d;
    end
  endtask

  // one access by master k; counts BUSY cycles up to completion
  task automatic access(input int k, input logic we, input logic [15:0] a,
                        input logic [31:0] d, output int bcnt,
                        output logic [31:0] rd, output bit ok);
    @(posedge clk); #1;
    drive(k, 1'b1, we, a, d);
    bcnt = 0; ok = 1'b0; rd = 32'h0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      if (grant != 2'b00) bcnt++;
      if (k == 0 ? m0_ready : m1_ready) begin
        ok = 1'b1;
        rd = (k == 0) ? m0_rdata : m1_rdata;
      end
    end
    @(posedge clk); #1;
    drive(k, 1'b0, we, a, d);
  endtask

  // transaction-level model for randomized traffic
  logic [31:0] mm [8];
  bit pend [2];
  int foreign [2];

  task automatic master(input int k, input int n);
    logic we;
    logic [15:0] a;
    logic [31:0] d, rd;
    bit got;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      we = 1'($urandom_range(0, 1));
      a = 16'($urandom_range(0, 7));
      d = $urandom;
      @(posedge clk); #1;
      foreign[k] = 0;
      pend[k] = 1'b1;
      drive(k, 1'b1, we, a, d);
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
        @(negedge clk);
        if (k == 0 ? m0_ready : m1_ready) begin
          got = 1'b1;
          rd = (k == 0) ? m0_rdata : m1_rdata;
          if (!we) chk($sformatf("rnd_m%0d_rdata", k), rd, mm[a[2:0]]);
          else mm[a[2:0]] = d;
          chk($sformatf("rnd_m%0d_fair", k),
              {31'h0, foreign[k] <= 1}, 32'h1);
          if (pend[1-k]) foreign[1-k]++;
        end
      end
      if (!got) chk($sformatf("rnd_m%0d_ready_timeout", k), 32'h0, 32'h1);
      @(posedge clk); #1;
      pend[k] = 1'b0;
      drive(k, 1'b0, we, a, d);
    end
  endtask

  int bc;
  logic [31:0] rd;
  bit ok;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd2, 16'd2, 32'h1111, 32'h2222,
               2'b01, 2'b10, 32'h0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 16'd0, 32'h0, 32'h0,
               2'b01, 2'b00, 32'h2222, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 16'd0, 32'hA5A5, 32'h0,
               2'b01, 2'b00, 32'h0, 32'h0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0, 32'h0, 32'h0,
               2'b01, 2'b00, 32'hA5A5, 32'h0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd1, 16'd1, 32'h0, 32'h5A5A,
               2'b10, 2'b01, 32'h5A5A, 32'h0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd2, 32'h0, 32'h0,
               2'b10, 2'b00, 32'h0, 32'h2222};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd1, 32'h0, 32'h0,
               2'b10, 2'b00, 32'h0, 32'h5A5A};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd2, 16'd1, 32'h0, 32'h0,
               2'b01, 2'b10, 32'h2222, 32'h5A5A};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd3, 16'd3, 32'h33, 32'h44,
               2'b01, 2'b10, 32'h0, 32'h0};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 16'd0, 32'h0, 32'h0,
               2'b01, 2'b00, 32'h44, 32'h0};

    rst = 1'b1; err_clr = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_grant", {30'h0, grant}, 32'h0);
    chk("reset_sreq_err", {30'h0, s_req, err}, 32'h0);
    chk("reset_ready", {30'h0, m0_ready, m1_ready}, 32'h0);
    chk("reset_rdata", m0_rdata | m1_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) run_round(i, tbl[i]);

    // minimum latency: IDLE grant then BUSY with immediate s_ready
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 16'd1, 32'h0);
    @(negedge clk);
    chk("lat_idle_grant", {30'h0, grant}, 32'h0);
    chk("lat_idle_ready", {31'h0, m0_ready}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_busy_grant", {30'h0, grant}, 32'h1);
    chk("lat_busy_ready", {31'h0, m0_ready}, 32'h1);
    chk("lat_busy_rdata", m0_rdata, 32'h5A5A);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 16'd1, 32'h0);
    @(negedge clk);
    chk("release_grant", {30'h0, grant}, 32'h0);
    chk("release_ready", {31'h0, m0_ready}, 32'h0);

    // hung slave: error completion after TIMEOUT busy cycles
    hang = 1'b1;
    access(0, 1'b0, 16'd1, 32'h0, bc, rd, ok);
    chk("tmo_ok", {31'h0, ok}, 32'h1);
    chk("tmo_cycles", bc, 32'd16);
    chk("tmo_rdata", rd, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("tmo_err_set", {31'h0, err}, 32'h1);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk("err_clr", {31'h0, err}, 32'h0);
    hang = 1'b0;

    // s_ready on the last allowed cycle beats the timeout
    lat_cfg = 15;
    access(1, 1'b0, 16'd1, 32'h0, bc, rd, ok);
    chk("edge_cycles", bc, 32'd16);
    chk("edge_rdata", rd, 32'h5A5A);
    @(negedge clk);
    chk("edge_err", {31'h0, err}, 32'h0);
    lat_cfg = 0;

    // err_clr held through a timeout: set wins
    hang = 1'b1;
    err_clr = 1'b1;
    access(0, 1'b0, 16'd1, 32'h0, bc, rd, ok);
    @(negedge clk);
    chk("clr_vs_set", {31'h0, err}, 32'h1);
    err_clr = 1'b0;

    // reset in the middle of BUSY with m1 waiting
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 16'd1, 32'h0);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, 16'd4, 32'h77);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_grant", {30'h0, grant}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 16'd1, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    hang = 1'b0;
    @(negedge clk);
    chk("rst_busy_sreq", {31'h0, s_req}, 32'h0);
    chk("rst_busy_grant", {30'h0, grant}, 32'h0);
    chk("rst_busy_err", {31'h0, err}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_m1_grant", {30'h0, grant}, 32'h2);
    chk("rst_m1_ready", {31'h0, m1_ready}, 32'h1);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b1, 16'd4, 32'h77);

    // randomized traffic from both masters
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mm[i] = 32'h0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    rnd_mode = 1'b1;
    fork
      master(0, 40);
      master(1, 40);
    join
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mmio_rr_arbiter.md
Name: mmio_rr_arbiter

Overview:
- Two-master round-robin arbiter that shares one MMIO slave port (e.g. led_uart_mmio) between two requesters, such as the CPU data port and a debug/DMA master.
- Sits between the masters' MMIO ports and the IO peripheral block.
- Uses the codebase MMIO handshake: req is held until ready, and ready qualifies rdata.
- Adds a bus timeout so a hung slave cannot stall a master.

Parameters:
- ADDR_W, `ADDR_W, address width.
- XLEN, `XLEN, data width.
- TIMEOUT, 255, max cycles in BUSY without s_ready before an error completion; 0 disables the timeout.
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on a timed-out access.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  master 0 request; held until m0_ready.
- m0_we  in  1  master 0 write enable.
- m0_addr  in  ADDR_W  master 0 address.
- m0_wdata  in  XLEN  master 0 write data.
- m0_rdata  out  XLEN  master 0 read data; valid when m0_ready=1.
- m0_ready  out  1  master 0 completion pulse.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ready: same as m0, for master 1.
- s_req  out  1  slave request.
- s_we  out  1  slave write enable.
- s_addr  out  ADDR_W  slave address.
- s_wdata  out  XLEN  slave write data.
- s_rdata  in  XLEN  slave read data.
- s_ready  in  1  slave completion.
- grant  out  2  one-hot owner; 00 when idle.
- err  out  1  sticky timeout flag.
- err_clr  in  1  clears err.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on rst.
- States: IDLE, BUSY, RELEASE.
- Reset (any state, including mid-transaction): state=IDLE, grant=00, s_req=0, m*_ready=0, m*_rdata=0, err=0, timeout counter=0, last=1 (so m0 wins the first tie).
- IDLE: grant is computed from the requests registered this cycle.
  - Only m0_req: grant m0.
  - Only m1_req: grant m1.
  - Both: grant the master that is not `last`.
  - Next state is BUSY with the owner latched. Counter cleared.
- BUSY signals:
  - s_req=1.
  - s_we/s_addr/s_wdata come combinationally from the owner's inputs.
  - The non-owner's ready=0 and rdata=0.
- BUSY, on s_ready=1:
  - Owner's ready=1 and rdata=s_rdata in the same cycle (combinational passthrough).
  - Next state RELEASE; last=owner.
- BUSY, s_ready=0: counter increments.
- Timeout: if TIMEOUT!=0 and the counter reaches TIMEOUT-1 with s_ready still 0:
  - Owner's ready=1, rdata=ERR_DATA, err set.
  - Next state RELEASE; last=owner.
- RELEASE (one cycle):
  - s_req=0, grant=00, all ready=0.
  - This lets the completing master drop req so its transaction is not re-issued.
  - Next state IDLE; arbitration happens again there.
- Minimum request-to-ready latency: 2 cycles (IDLE grant, then BUSY with an immediate s_ready).
- Back-to-back use by the same master: at least 3 cycles per access.
- Simultaneous events:
  - A request arriving while BUSY or RELEASE waits; it is never dropped as long as it is held.
  - If s_ready and the timeout coincide, s_ready wins: normal data, err unchanged.
  - err_clr and a timeout set in the same cycle: set wins.
- Masters must keep their inputs stable while req=1. Dropping req during BUSY is illegal; the arbiter still completes to the latched owner.
- A master requesting alone is granted immediately regardless of `last`.

Test Plan:
- Reset, then m0 writes LED_ADDR=0x0000A5A5 via led_uart_mmio (slave rst_n=~rst), then reads it back → m0_ready pulses once per access, m0_rdata[15:0]=0xA5A5, led_out=0xA5A5, m1_ready stays 0.
- m0 and m1 assert req in the same cycle (m0 writes LED=0x1111, m1 writes LED=0x2222) → m0 granted first, m1 second; final led_out=0x2222; grant sequence 01,00,10.
- Both masters issue 4 back-to-back writes each → grants alternate m0,m1,m0,m1…; neither master waits more than one foreign transaction.
- m1 writes UART_TX=0x55 while m0 polls UART_STAT → m0 reads busy=1; after 10*UART_DIV+4 cycles it reads busy=0; uart_tx=1.
- Stub slave with s_ready tied 0, TIMEOUT=16; m0 reads → m0_ready asserts 16 cycles after BUSY entry, m0_rdata=0xDEADBEEF, err=1; err_clr → err=0; next access proceeds.
- Assert rst during BUSY → the next cycle has s_req=0, grant=00, err=0; m1 waiting alone is then granted on the first IDLE cycle.
